// File: rtl/ram_access_sequencer_if.sv
// Bus bundle between the core memory stage, the data-side sequencer and the
// RAM's read port B / write port.
//   slave  : the sequencer's view (takes requests and RAM read data, drives
//            responses and the RAM read/write addresses, data and enable)
//   master : the core + RAM side (drives requests and RAM read data)
// Request : req_valid, req_ready, req_write, req_funct3, req_addr, req_wdata
// Response: rsp_valid, rsp_rdata, rsp_error
// RAM     : ram_read_address, ram_data_out, ram_write_address, ram_data_in,
//           ram_write_enable
interface ram_access_sequencer_if #(
  parameter int RAM_A_WIDTH = 12
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [2:0]             req_funct3;
  logic [31:0]            req_addr;
  logic [31:0]            req_wdata;
  logic                   rsp_valid;
  logic [31:0]            rsp_rdata;
  logic                   rsp_error;
  logic [RAM_A_WIDTH-1:0] ram_read_address;
  logic [31:0]            ram_data_out;
  logic [RAM_A_WIDTH-1:0] ram_write_address;
  logic [31:0]            ram_data_in;
  logic                   ram_write_enable;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, ram_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           ram_read_address, ram_write_address, ram_data_in, ram_write_enable
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, ram_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           ram_read_address, ram_write_address, ram_data_in, ram_write_enable
  );
endinterface

// File: rtl/ram_access_sequencer.sv
// Data-side controller for a single-write-port, registered-read 32-bit word
// RAM without byte enables. Takes one RISC-V load/store at a time, turns
// SB/SH into read-modify-write on RAM port B + write port, extracts and
// extends sub-word load data, and flags misaligned / illegal-width accesses.
// Ports:
//   clock : single clock, posedge
//   reset : synchronous, active-high
//   bus   : ram_access_sequencer_if.slave (request, response, RAM port B and
//           write port signals)
module ram_access_sequencer #(
  parameter int RAM_A_WIDTH = 12
) (
  input  logic                   clock,
  input  logic                   reset,
  ram_access_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [RAM_A_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]             lane_q, lane_d;
  logic [2:0]             f3_q, f3_d;
  logic                   wr_q, wr_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [31:0]            merge_q, merge_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_error_q, rsp_error_d;

  logic        accept;
  logic        req_err;
  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  // Upper address bits alias onto the RAM and are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:RAM_A_WIDTH+2];

  assign bus.req_ready         = (state_q == IDLE) && !reset;
  assign accept                = bus.req_valid && bus.req_ready;
  // In IDLE the RAM samples the request's word index on the accept edge.
  assign bus.ram_read_address  = (state_q == IDLE) ? bus.req_addr[RAM_A_WIDTH+1:2] : idx_q;
  assign bus.ram_write_enable  = (state_q == WRITE) && !reset;
  assign bus.ram_write_address = idx_q;
  assign bus.ram_data_in       = merge_q;
  assign bus.rsp_valid         = rsp_valid_q;
  assign bus.rsp_rdata         = rsp_rdata_q;
  assign bus.rsp_error         = rsp_error_q;

  always_comb begin
    req_err = 1'b0;
    if (bus.req_write) begin
      if (!(bus.req_funct3 inside {3'b000, 3'b001, 3'b010})) req_err = 1'b1;
    end else begin
      if (bus.req_funct3 inside {3'b011, 3'b110, 3'b111}) req_err = 1'b1;
    end
    if ((bus.req_funct3 inside {3'b001, 3'b101}) && bus.req_addr[0]) req_err = 1'b1;
    if ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00)) req_err = 1'b1;
  end

  // Lane extraction for loads and lane replacement for SB/SH share one shifter
  // amount; SH is always half-aligned here so the 16-bit mask never straddles.
  always_comb begin
    shamt   = {lane_q, 3'b000};
    shifted = bus.ram_data_out >> shamt;
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h000000, shifted[7:0]};
      3'b101:  load_val = {16'h0000, shifted[15:0]};
      default: load_val = bus.ram_data_out;
    endcase
    lane_mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
    merged    = (bus.ram_data_out & ~lane_mask) | (({16'h0000, wdata_q} << shamt) & lane_mask);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    f3_d        = f3_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            idx_d   = bus.req_addr[RAM_A_WIDTH+1:2];
            lane_d  = bus.req_addr[1:0];
            f3_d    = bus.req_funct3;
            wr_d    = bus.req_write;
            wdata_d = bus.req_wdata[15:0];
            // Full-word stores need no read; skip straight to the write.
            if (bus.req_write && (bus.req_funct3 == 3'b010)) begin
              merge_d = bus.req_wdata;
              state_d = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (wr_q) begin
          merge_d = merged;
          state_d = WRITE;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          rsp_rdata_d = load_val;
          state_d     = IDLE;
        end
      end
      WRITE: begin
        rsp_valid_d = 1'b1;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lane_q      <= '0;
      f3_q        <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      merge_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      f3_q        <= f3_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      merge_q     <= merge_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule
